// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the single-clock FIFO.
// Geometry only; the FIFO adds no data types of its own.
package sync_fifo_pkg;

    localparam int FIFO_DEPTH_DEF = 16;
    localparam int FIFO_WIDTH_DEF = 8;

endpackage

// File: rtl/sync_fifo_mem.sv
// Purpose: DEPTH x WIDTH storage with one synchronous write port and one registered read port.
// Latency: a write lands at the clock edge; read data appears one cycle after rd_en.
// Backpressure: none here; the caller only issues accesses that are legal.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int WIDTH  = FIFO_WIDTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Reset does not clear the array; the pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with full/empty status and one-cycle overflow/underflow pulses.
// Latency: a word written at edge N is readable from edge N+1; read data is registered (1 cycle).
// Backpressure: writes while full and reads while empty are dropped and flagged next cycle.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = FIFO_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             overflow_o,
    output logic             empty_o,
    output logic             underflow_o
);

    localparam int PNT_WIDTH = $clog2(DEPTH);
    localparam logic [PNT_WIDTH:0] PTR_ONE = {{PNT_WIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra MSB that toggles on each wrap, separating full from empty.
    logic [PNT_WIDTH:0] wr_ptr;
    logic [PNT_WIDTH:0] rd_ptr;
    logic               wr_acc;
    logic               rd_acc;

    always_comb begin
        empty_o = (wr_ptr == rd_ptr);
        full_o  = (wr_ptr[PNT_WIDTH-1:0] == rd_ptr[PNT_WIDTH-1:0]) &&
                  (wr_ptr[PNT_WIDTH] != rd_ptr[PNT_WIDTH]);
        wr_acc  = wr_en_i && !full_o;
        rd_acc  = rd_en_i && !empty_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            overflow_o  <= wr_en_i && full_o;
            underflow_o <= rd_en_i && empty_o;
        end
    end

    // Reset gates the write so a concurrent request leaves no trace.
    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (PNT_WIDTH)
    ) u_mem (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wr_en (wr_acc && !rst_i),
        .waddr (wr_ptr[PNT_WIDTH-1:0]),
        .wdata (wdata_i),
        .rd_en (rd_acc),
        .raddr (rd_ptr[PNT_WIDTH-1:0]),
        .rdata (rdata_o)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: each driven cycle queues its expected post-edge state,
// and an independent monitor compares the DUT against it one cycle at a time.
module tb_sync_fifo;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         wr_en_i = 1'b0;
    logic         rd_en_i = 1'b0;
    logic [W-1:0] wdata_i = '0;
    logic [W-1:0] rdata_o;
    logic         full_o;
    logic         overflow_o;
    logic         empty_o;
    logic         underflow_o;

    always #5 clk_i = ~clk_i;

    sync_fifo #(.DEPTH(D), .WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .rd_en_i     (rd_en_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .full_o      (full_o),
        .overflow_o  (overflow_o),
        .empty_o     (empty_o),
        .underflow_o (underflow_o)
    );

    typedef struct {
        logic [W-1:0] rdata;
        logic         full;
        logic         empty;
        logic         ovf;
        logic         unf;
        int           step;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] model_q[$];
    logic [W-1:0] m_rdata = '0;
    int           tests = 0;
    int           fails = 0;
    int           step  = 0;

    task automatic chk(input string name, input int stp, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s step %0d: got %0d want %0d", name, stp, got, want);
        end
    endtask

    // One clock of stimulus; the reference queue decides what the DUT must show after the edge.
    task automatic cycle(input logic rst, input logic wr, input logic rd, input logic [W-1:0] d);
        exp_t e;
        logic was_full;
        logic was_empty;
        @(negedge clk_i);
        rst_i   = rst;
        wr_en_i = wr;
        rd_en_i = rd;
        wdata_i = d;
        was_full  = (model_q.size() == D);
        was_empty = (model_q.size() == 0);
        e.ovf = 1'b0;
        e.unf = 1'b0;
        if (rst) begin
            model_q.delete();
            m_rdata = '0;
        end else begin
            if (rd && !was_empty) m_rdata = model_q.pop_front();
            if (wr && !was_full)  model_q.push_back(d);
            e.ovf = wr && was_full;
            e.unf = rd && was_empty;
        end
        e.rdata = m_rdata;
        e.full  = (model_q.size() == D);
        e.empty = (model_q.size() == 0);
        e.step  = step;
        step++;
        exp_q.push_back(e);
        @(posedge clk_i);
    endtask

    task automatic wr(input logic [W-1:0] d);
        cycle(1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic rd();
        cycle(1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    always begin : monitor
        exp_t e;
        @(posedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rdata",     e.step, 32'(rdata_o),     32'(e.rdata));
            chk("full",      e.step, 32'(full_o),      32'(e.full));
            chk("empty",     e.step, 32'(empty_o),     32'(e.empty));
            chk("overflow",  e.step, 32'(overflow_o),  32'(e.ovf));
            chk("underflow", e.step, 32'(underflow_o), 32'(e.unf));
        end
    end

    initial begin
        logic [W-1:0] vec5 [5];
        vec5[0] = 8'd100; vec5[1] = 8'd150; vec5[2] = 8'd120; vec5[3] = 8'd200; vec5[4] = 8'd133;

        // Reset for 4 cycles, one of them with both requests raised.
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 8'hAA);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        idle();
        idle();

        for (int i = 0; i < 5; i++) wr(vec5[i]);
        for (int i = 0; i < 5; i++) rd();
        idle();

        // Fill, overflow twice back to back, drain, underflow twice back to back.
        for (int i = 0; i < D; i++) wr(8'(i * 11 + 1));
        wr(8'hEE);
        wr(8'hEF);
        idle();
        for (int i = 0; i < D + 1; i++) rd();
        rd();
        idle();

        // Wrap-around of both pointers.
        for (int i = 0; i < D; i++) wr(8'(i + 40));
        for (int i = 0; i < 8; i++) rd();
        for (int i = 0; i < 8; i++) wr(8'(i + 90));
        for (int i = 0; i < D; i++) rd();
        idle();

        // Simultaneous access at the empty and full boundaries.
        cycle(1'b0, 1'b1, 1'b1, 8'h5A);
        for (int i = 0; i < D - 1; i++) wr(8'(i + 200));
        cycle(1'b0, 1'b1, 1'b1, 8'h77);
        cycle(1'b0, 1'b1, 1'b1, 8'h78);
        for (int i = 0; i < D; i++) rd();
        idle();

        // Mixed concurrent traffic with random gaps.
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end
        for (int i = 0; i < D + 1; i++) rd();

        // Reset while holding 7 words discards them.
        for (int i = 0; i < 7; i++) wr(8'(i + 60));
        cycle(1'b1, 1'b0, 1'b0, '0);
        rd();
        idle();

        repeat (3) @(posedge clk_i);
        #2;
        chk("scoreboard_drained", step, 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
